// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared types and constants for the divider issue controller:
//            FSM state encoding, default timeout, divide-by-zero quotient
//            and the bit positions of the packed divider result.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ARM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } div_state_e;

    // Default number of ARM+WAIT cycles before giving up on the divider
    localparam int TIMEOUT_DEFAULT = 1024;

    // Quotient reported for a zero divisor (all ones)
    localparam logic [31:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

    // Field positions inside div_result = {remainder, quotient}
    localparam int QUOT_LSB = 0;
    localparam int QUOT_MSB = 31;
    localparam int REM_LSB  = 32;
    localparam int REM_MSB  = 63;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_issue_ctrl
// Purpose  : Issues one signed 64/32 divide at a time to an external divider,
//            shortcuts divide-by-zero, ignores a stale done level left over
//            from the previous operation, and bounds the wait with a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    // request side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_divisor,
    input  logic [63:0] req_dividend,
    input  logic [3:0]  req_tag,
    // divider side
    output logic [31:0] div_opera1,
    output logic [63:0] div_opera2,
    output logic        div_start,
    output logic        div_muordi,
    input  logic [63:0] div_result,
    input  logic        div_valid,
    // response side
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_quotient,
    output logic [31:0] rsp_remainder,
    output logic [3:0]  rsp_tag,
    output logic        rsp_dbz,
    output logic        rsp_timeout
);

    // Counter wide enough to reach TIMEOUT-1
    localparam int             CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    div_state_e        state_q, state_d;
    logic              run_q;
    logic [31:0]       opa_q,   opa_d;
    logic [63:0]       opb_q,   opb_d;
    logic [3:0]        tag_q,   tag_d;
    logic [31:0]       quot_q,  quot_d;
    logic [31:0]       rem_q,   rem_d;
    logic              dbz_q,   dbz_d;
    logic              tmo_q,   tmo_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              accept;
    logic              cnt_done;

    assign accept   = req_valid && req_ready;
    assign cnt_done = (cnt_q == CNT_LAST);

    // State, holding and result registers; reset aborts any operation silently
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            tag_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            tag_q   <= tag_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update for the issue sequence
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        tag_d   = tag_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    opa_d = req_divisor;
                    opb_d = req_dividend;
                    tag_d = req_tag;
                    if (req_divisor == 32'd0) begin
                        // Zero divisor never reaches the divider
                        quot_d  = DBZ_QUOTIENT;
                        rem_d   = req_dividend[31:0];
                        dbz_d   = 1'b1;
                        tmo_d   = 1'b0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_ARM;
            end
            ST_ARM: begin
                // A high done level here belongs to the previous operation
                if (cnt_done) begin
                    quot_d  = '0;
                    rem_d   = '0;
                    dbz_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!div_valid) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Completion wins over a timeout landing in the same cycle
                if (div_valid) begin
                    quot_d  = div_result[QUOT_MSB:QUOT_LSB];
                    rem_d   = div_result[REM_MSB:REM_LSB];
                    dbz_d   = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_done) begin
                    quot_d  = '0;
                    rem_d   = '0;
                    dbz_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state and held registers
    always_comb begin
        req_ready  = run_q && (state_q == ST_IDLE);
        div_muordi = run_q;
        div_start  = (state_q == ST_START);
        if ((state_q == ST_START) || (state_q == ST_ARM) || (state_q == ST_WAIT)) begin
            div_opera1 = opa_q;
            div_opera2 = opb_q;
        end else begin
            div_opera1 = '0;
            div_opera2 = '0;
        end
        rsp_valid     = (state_q == ST_RESP);
        rsp_quotient  = quot_q;
        rsp_remainder = rem_q;
        rsp_tag       = tag_q;
        rsp_dbz       = dbz_q;
        rsp_timeout   = tmo_q;
    end

endmodule : div_issue_ctrl
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_issue_ctrl
// Purpose  : Directed self-checking bench for div_issue_ctrl with a small
//            behavioural divider (normal, stale-done and never-done modes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_issue_ctrl;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_divisor;
    logic [63:0] req_dividend;
    logic [3:0]  req_tag;
    logic [31:0] div_opera1;
    logic [63:0] div_opera2;
    logic        div_start;
    logic        div_muordi;
    logic [63:0] div_result;
    logic        div_valid;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_quotient;
    logic [31:0] rsp_remainder;
    logic [3:0]  rsp_tag;
    logic        rsp_dbz;
    logic        rsp_timeout;

    int errors = 0;
    int checks = 0;

    // divider model controls: 0 normal, 1 stale done for 3 cycles, 2 never done
    int          m_mode  = 0;
    int          m_delay = 0;
    int          remain  = 0;
    int          stale_left = 0;
    bit          pending = 0;
    logic [63:0] pend_res;
    int          start_cnt = 0;

    div_issue_ctrl #(.TIMEOUT(16)) u_dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_divisor   (req_divisor),
        .req_dividend  (req_dividend),
        .req_tag       (req_tag),
        .div_opera1    (div_opera1),
        .div_opera2    (div_opera2),
        .div_start     (div_start),
        .div_muordi    (div_muordi),
        .div_result    (div_result),
        .div_valid     (div_valid),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_tag       (rsp_tag),
        .rsp_dbz       (rsp_dbz),
        .rsp_timeout   (rsp_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Start pulse counter
    always @(negedge clock) begin
        if (div_start) start_cnt++;
    end

    // Behavioural divider, updated on the falling edge
    always @(negedge clock) begin
        logic signed [63:0] a;
        logic signed [63:0] b;
        logic signed [63:0] q;
        logic signed [63:0] r;
        if (div_start) begin
            a = $signed(div_opera2);
            b = $signed({{32{div_opera1[31]}}, div_opera1});
            q = a / b;
            r = a % b;
            pend_res = {r[31:0], q[31:0]};
            if (m_mode == 1) begin
                stale_left = 3;
                pending    = 1'b0;
            end else begin
                div_valid  = 1'b0;
                stale_left = 0;
                remain     = m_delay;
                pending    = (m_mode == 0);
            end
        end else if (stale_left > 0) begin
            stale_left--;
            if (stale_left == 0) begin
                div_valid = 1'b0;
                remain    = m_delay;
                pending   = 1'b1;
            end
        end else if (pending) begin
            if (remain == 0) begin
                div_valid  = 1'b1;
                div_result = pend_res;
                pending    = 1'b0;
            end else begin
                remain--;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer one request for exactly one clock edge
    task automatic do_req(input logic [31:0] dvs, input logic [63:0] dvd, input logic [3:0] tag);
        req_divisor  = dvs;
        req_dividend = dvd;
        req_tag      = tag;
        req_valid    = 1'b1;
        tick();
        req_valid    = 1'b0;
    endtask

    task automatic wait_rsp(input int max, output int n);
        n = 0;
        while (!rsp_valid && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    int n;
    int s0;
    bit stable;
    bit quiet;
    logic [31:0] sq, sr;
    logic [3:0]  st;

    initial begin
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_divisor  = '0;
        req_dividend = '0;
        req_tag      = '0;
        rsp_ready    = 1'b0;
        div_valid    = 1'b0;
        div_result   = '0;

        // Reset state
        #12;
        check("rst_req_ready", req_ready, 0);
        check("rst_muordi", div_muordi, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_div_start", div_start, 0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("rel_req_ready", req_ready, 1);
        check("rel_muordi", div_muordi, 1);
        check("idle_opera1", div_opera1, 0);

        // Normal divide 100 / 7
        m_mode = 0; m_delay = 2; s0 = start_cnt;
        do_req(32'd7, 64'd100, 4'hA);
        check("nrm_start", div_start, 1);
        check("nrm_opera1", div_opera1, 7);
        check("nrm_opera2", div_opera2, 100);
        wait_rsp(40, n);
        check("nrm_rsp_seen", rsp_valid, 1);
        check("nrm_starts", start_cnt - s0, 1);
        check("nrm_quot", rsp_quotient, 14);
        check("nrm_rem", rsp_remainder, 2);
        check("nrm_dbz", rsp_dbz, 0);
        check("nrm_tmo", rsp_timeout, 0);
        check("nrm_tag", rsp_tag, 4'hA);
        consume();
        check("nrm_done_valid", rsp_valid, 0);
        check("nrm_done_ready", req_ready, 1);

        // Signed divide 130456 / -1500
        m_delay = 3;
        do_req(-32'sd1500, 64'd130456, 4'h3);
        wait_rsp(40, n);
        check("sgn_rsp_seen", rsp_valid, 1);
        check("sgn_quot", rsp_quotient, 32'hFFFF_FFAA);
        check("sgn_rem", rsp_remainder, 32'h0000_05B0);
        consume();

        // Divide by zero: response one cycle after acceptance, no start
        s0 = start_cnt;
        do_req(32'd0, 64'h0000_0001_DEAD_BEEF, 4'h5);
        check("dbz_latency", rsp_valid, 1);
        check("dbz_start", div_start, 0);
        check("dbz_quot", rsp_quotient, 32'hFFFF_FFFF);
        check("dbz_rem", rsp_remainder, 32'hDEAD_BEEF);
        check("dbz_flag", rsp_dbz, 1);
        check("dbz_tmo", rsp_timeout, 0);
        consume();
        check("dbz_starts", start_cnt - s0, 0);

        // Stale done level from the previous op held for 3 cycles
        m_mode = 1; m_delay = 1;
        do_req(32'd33, 64'd1000, 4'h6);
        wait_rsp(40, n);
        check("stl_rsp_seen", rsp_valid, 1);
        check("stl_quot", rsp_quotient, 30);
        check("stl_rem", rsp_remainder, 10);
        consume();

        // Completion in the last counted cycle beats the timeout
        m_mode = 0; m_delay = 15;
        do_req(32'd10, 64'd95, 4'h7);
        wait_rsp(40, n);
        check("pri_cycles", n, 17);
        check("pri_tmo", rsp_timeout, 0);
        check("pri_quot", rsp_quotient, 9);
        check("pri_rem", rsp_remainder, 5);
        consume();

        // Timeout: divider never completes
        m_mode = 2;
        do_req(32'd3, 64'd9, 4'h8);
        wait_rsp(40, n);
        check("tmo_cycles", n, 17);
        check("tmo_flag", rsp_timeout, 1);
        check("tmo_quot", rsp_quotient, 0);
        check("tmo_rem", rsp_remainder, 0);
        check("tmo_dbz", rsp_dbz, 0);
        check("tmo_tag", rsp_tag, 4'h8);
        consume();

        // Backpressure with a competing request held outside IDLE
        m_mode = 0; m_delay = 1; s0 = start_cnt;
        do_req(-32'sd7, 64'd50, 4'h9);
        wait_rsp(40, n);
        check("bp_rsp_seen", rsp_valid, 1);
        check("bp_quot", rsp_quotient, 32'hFFFF_FFF9);
        check("bp_rem", rsp_remainder, 1);
        sq = rsp_quotient; sr = rsp_remainder; st = rsp_tag;
        req_divisor = 32'd1; req_dividend = 64'd2; req_tag = 4'hF; req_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!rsp_valid || rsp_quotient !== sq || rsp_remainder !== sr || rsp_tag !== st)
                stable = 1'b0;
        end
        req_valid = 1'b0;
        check("bp_stable", stable, 1);
        check("bp_tag", rsp_tag, 4'h9);
        check("bp_starts", start_cnt - s0, 1);
        consume();
        check("bp_done_valid", rsp_valid, 0);

        // Reset asserted while waiting on the divider
        m_mode = 2;
        do_req(32'd5, 64'd20, 4'hC);
        repeat (4) tick();
        reset = 1'b0;
        #1;
        check("arst_req_ready", req_ready, 0);
        check("arst_muordi", div_muordi, 0);
        check("arst_opera1", div_opera1, 0);
        check("arst_opera2", div_opera2, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_tag", rsp_tag, 0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("arst_rel_ready", req_ready, 1);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid || div_start) quiet = 1'b0;
        end
        check("arst_no_rsp", quiet, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_div_issue_ctrl
`default_nettype wire
